// File: rtl/hardcaml_sdram_pkg.sv
// rtl/hardcaml_sdram_pkg.sv - shared types and limits for the SDRAM DQ datapath
package hardcaml_sdram_pkg;

  // Bus ownership state of the DQ pins
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_TURN  = 2'd3
  } dq_state_e;

  localparam int         CAS_MIN  = 2;
  localparam int         CAS_MAX  = 3;
  localparam logic [1:0] TURN_MAX = 2'd3;

  // Two-bit increment that sticks at TURN_MAX instead of wrapping
  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    if (v >= TURN_MAX) begin
      return v;
    end
    return v + 2'd1;
  endfunction

endpackage

// File: rtl/hardcaml_tristate_buffer.sv
// rtl/hardcaml_tristate_buffer.sv - bidirectional pad: drives io when en, always returns io
module hardcaml_tristate_buffer #(
  parameter int b = 16
) (
  input  logic         en,
  input  logic [b-1:0] i,
  output logic [b-1:0] o,
  inout  wire  [b-1:0] io
);

  assign io = en ? i : {b{1'bz}};
  assign o  = io;

endmodule

// File: rtl/hardcaml_sdram_dq_io.sv
// rtl/hardcaml_sdram_dq_io.sv - SDRAM DQ bus owner: write drive, CAS-aligned read capture, turnaround
module hardcaml_sdram_dq_io
  import hardcaml_sdram_pkg::*;
#(
  parameter int DW   = 16,
  parameter int CAS  = 2,
  parameter int TURN = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            rd_cmd,
  input  logic            wr_valid,
  input  logic [DW-1:0]   wr_data,
  input  logic [DW/8-1:0] wr_mask,
  output logic            wr_ready,
  output logic            rd_valid,
  output logic [DW-1:0]   rd_data,
  output logic            busy,
  output logic [DW/8-1:0] dq_dqm,
  inout  wire  [DW-1:0]   dq
);

  localparam int         MW        = DW / 8;
  localparam logic [1:0] TURN_LAST = 2'(TURN - 1);

  dq_state_e       state_q, state_d;
  logic [CAS:0]    rd_pipe_q, rd_pipe_d;
  logic [1:0]      turn_cnt_q, turn_cnt_d;
  logic            dq_oe_q, dq_oe_d;
  logic [DW-1:0]   dq_out_q, dq_out_d;
  logic [MW-1:0]   dqm_q, dqm_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic [DW-1:0]   dq_in;
  logic            wr_accept;
  logic            rd_inflight_d;

  // Pad: the only place dq is driven from this block
  hardcaml_tristate_buffer #(.b(DW)) u_dq_pad (
    .en (dq_oe_q),
    .i  (dq_out_q),
    .o  (dq_in),
    .io (dq)
  );

  // A read on the command bus always beats a write offered in the same cycle
  assign wr_ready  = !reset && !rd_cmd && (state_q == ST_IDLE || state_q == ST_WRITE);
  assign wr_accept = wr_valid && wr_ready;

  // Bit k of the pipe marks a read issued k+1 cycles ago; top bit lines up with rd_valid
  assign rd_pipe_d     = {rd_pipe_q[CAS-1:0], rd_cmd};
  // Beats still waiting for their data on the pins (capture not yet done)
  assign rd_inflight_d = |rd_pipe_d[CAS-1:0];

  assign rd_valid = rd_pipe_q[CAS];
  assign rd_data  = rd_data_q;
  assign busy     = (|rd_pipe_q) || (state_q == ST_TURN);
  assign dq_dqm   = dqm_q;

  // Next bus owner; turnaround counter restarts on every entry to TURN
  always_comb begin
    state_d    = state_q;
    turn_cnt_d = 2'd0;
    if (rd_cmd) begin
      state_d = ST_READ;
    end else begin
      case (state_q)
        ST_IDLE, ST_WRITE: state_d = wr_accept ? ST_WRITE : ST_IDLE;
        ST_READ:           state_d = rd_inflight_d ? ST_READ : ST_TURN;
        ST_TURN: begin
          if (turn_cnt_q >= TURN_LAST) begin
            state_d = ST_IDLE;
          end else begin
            state_d    = ST_TURN;
            turn_cnt_d = sat_inc2(turn_cnt_q);
          end
        end
        default:           state_d = ST_IDLE;
      endcase
    end
  end

  // Pin drive, DQM and read capture for the next cycle
  always_comb begin
    dq_oe_d   = wr_accept;
    dq_out_d  = wr_accept ? wr_data : dq_out_q;
    rd_data_d = rd_pipe_q[CAS-1] ? dq_in : rd_data_q;
    if (rd_inflight_d) begin
      dqm_d = '0;
    end else if (wr_accept) begin
      dqm_d = wr_mask;
    end else begin
      dqm_d = '1;
    end
  end

  // State and datapath registers; reset releases the bus immediately
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rd_pipe_q  <= '0;
      turn_cnt_q <= 2'd0;
      dq_oe_q    <= 1'b0;
      dq_out_q   <= '0;
      dqm_q      <= '1;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rd_pipe_q  <= rd_pipe_d;
      turn_cnt_q <= turn_cnt_d;
      dq_oe_q    <= dq_oe_d;
      dq_out_q   <= dq_out_d;
      dqm_q      <= dqm_d;
      rd_data_q  <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_hardcaml_sdram_dq_io.sv
// tb/tb_hardcaml_sdram_dq_io.sv - self-checking bench for hardcaml_sdram_dq_io
module tb_hardcaml_sdram_dq_io;

  localparam int DW   = 16;
  localparam int CAS  = 2;
  localparam int TURN = 1;
  localparam int WIN  = CAS + TURN;
  localparam int MAXC = 8192;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rd_cmd = 1'b0;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_mask = '0;
  logic        wr_ready;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        busy;
  logic [1:0]  dq_dqm;
  wire  [15:0] dq;

  logic        tb_oe = 1'b0;
  logic [15:0] tb_dq = '0;
  assign dq = tb_oe ? tb_dq : 16'hzzzz;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_rst = -1;

  bit          rd_hist  [MAXC];
  bit          acc_hist [MAXC];
  logic [15:0] wd_hist  [MAXC];
  logic [1:0]  wm_hist  [MAXC];
  logic [15:0] ret_hist [MAXC];

  hardcaml_sdram_dq_io #(.DW(DW), .CAS(CAS), .TURN(TURN)) dut (
    .clock    (clock),
    .reset    (reset),
    .rd_cmd   (rd_cmd),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_mask  (wr_mask),
    .wr_ready (wr_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .busy     (busy),
    .dq_dqm   (dq_dqm),
    .dq       (dq)
  );

  always #10 clock = ~clock;

  function automatic bit rd_at(input int c);
    if (c < 0 || c <= last_rst) return 1'b0;
    return rd_hist[c];
  endfunction

  function automatic bit acc_at(input int c);
    if (c < 0 || c <= last_rst) return 1'b0;
    return acc_hist[c];
  endfunction

  // Any read issued between lo and hi cycles before cycle c
  function automatic bit rd_within(input int c, input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      if (rd_at(c - k)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model compare: expectations from read/accept history, every cycle
  bit         e_ready, e_busy, e_valid, e_oe;
  logic [1:0] e_dqm;
  always @(negedge clock) begin
    if (reset) begin
      check("rst_wr_ready", int'(wr_ready), 0);
      check("rst_rd_valid", int'(rd_valid), 0);
      check("rst_rd_data",  int'(rd_data), 0);
      check("rst_dqm",      int'(dq_dqm), 'h3);
      check("rst_dq_oe",    int'(dut.dq_oe_q), 0);
      check("rst_busy",     int'(busy), 0);
      last_rst = cyc;
    end else begin
      e_ready = !rd_cmd && !rd_within(cyc, 1, WIN);
      e_busy  = rd_within(cyc, 1, WIN);
      e_valid = rd_at(cyc - CAS - 1);
      e_oe    = acc_at(cyc - 1);
      if (rd_within(cyc, 1, CAS)) e_dqm = 2'b00;
      else if (e_oe)              e_dqm = wm_hist[cyc-1];
      else                        e_dqm = 2'b11;
      check("wr_ready", int'(wr_ready), int'(e_ready));
      check("busy",     int'(busy), int'(e_busy));
      check("rd_valid", int'(rd_valid), int'(e_valid));
      check("dq_dqm",   int'(dq_dqm), int'(e_dqm));
      if (e_valid) check("rd_data", int'(rd_data), int'(ret_hist[cyc-1]));
      if (e_oe) check("dq_drive", int'(dq), int'(wd_hist[cyc-1]));
      else      check("dq_release", int'(dut.dq_oe_q), 0);
      rd_hist[cyc]  = rd_cmd;
      acc_hist[cyc] = wr_valid && e_ready;
      wd_hist[cyc]  = wr_data;
      wm_hist[cyc]  = wr_mask;
      ret_hist[cyc] = tb_dq;
    end
    cyc++;
  end

  // One clock cycle of stimulus; the bench plays SDRAM and returns read data CAS cycles later
  task automatic step(input bit rd, input bit wv, input logic [15:0] wd,
                      input logic [1:0] wm, input logic [15:0] ret);
    @(posedge clock);
    #1;
    rd_cmd   = rd;
    wr_valid = wv;
    wr_data  = wd;
    wr_mask  = wm;
    tb_oe    = !reset && rd_at(cyc - CAS);
    tb_dq    = ret;
    #5;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
  endtask

  // Assert reset mid-cycle, confirm the bus lets go at once, hold one cycle, release
  task automatic reset_pulse();
    reset = 1'b1;
    #1;
    check("async_rel_oe", int'(dut.dq_oe_q), 0);
    check("async_rel_dqm", int'(dq_dqm), 'h3);
    step(1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", int'(wr_ready), 1);
  endtask

  initial begin
    idle(3);
    reset = 1'b0;

    // idle after reset release
    for (int k = 0; k < 10; k++) begin
      idle(1);
      check("idle_ready", int'(wr_ready), 1);
      check("idle_dqm", int'(dq_dqm), 'h3);
      check("idle_oe", int'(dut.dq_oe_q), 0);
    end

    // write burst
    step(1'b0, 1'b1, 16'hA5A5, 2'b00, 16'h0);
    check("burst_ready", int'(wr_ready), 1);
    step(1'b0, 1'b1, 16'h5A5A, 2'b01, 16'h0);
    check("burst_dq0", int'(dq), 'hA5A5);
    idle(1);
    check("burst_dq1", int'(dq), 'h5A5A);
    check("burst_dqm1", int'(dq_dqm), 'h1);
    idle(1);
    check("burst_end_oe", int'(dut.dq_oe_q), 0);
    idle(2);

    // single read, CAS 2
    step(1'b1, 1'b0, 16'h0, 2'b00, 16'h1234);
    step(1'b0, 1'b0, 16'h0, 2'b00, 16'h1234);
    check("rd_dqm_low", int'(dq_dqm), 0);
    step(1'b0, 1'b0, 16'h0, 2'b00, 16'h1234);
    idle(1);
    check("rd3_valid", int'(rd_valid), 1);
    check("rd3_data", int'(rd_data), 'h1234);
    idle(1);
    check("rd4_valid", int'(rd_valid), 0);
    idle(3);

    // read-to-write turnaround
    step(1'b1, 1'b0, 16'h0, 2'b00, 16'h4321);
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 1'b1, 16'hBEEF, 2'b10, 16'h4321);
      check("turn_blocked", int'(wr_ready), 0);
    end
    step(1'b0, 1'b1, 16'hBEEF, 2'b10, 16'h4321);
    check("turn_accept", int'(wr_ready), 1);
    idle(1);
    check("turn_dq", int'(dq), 'hBEEF);
    idle(3);

    // read and write together: read wins
    step(1'b1, 1'b1, 16'hDEAD, 2'b00, 16'h0F0F);
    check("tie_ready", int'(wr_ready), 0);
    step(1'b0, 1'b0, 16'h0, 2'b00, 16'h0F0F);
    check("tie_no_drive", int'(dut.dq_oe_q), 0);
    step(1'b0, 1'b0, 16'h0, 2'b00, 16'h0F0F);
    idle(1);
    check("tie_rd_valid", int'(rd_valid), 1);
    check("tie_rd_data", int'(rd_data), 'h0F0F);
    idle(3);

    // reset while driving a write
    step(1'b0, 1'b1, 16'h7777, 2'b00, 16'h0);
    idle(1);
    check("pre_rst_dq", int'(dq), 'h7777);
    reset_pulse();
    idle(2);

    // reset with a read in flight: never returns
    step(1'b1, 1'b0, 16'h0, 2'b00, 16'h9999);
    idle(1);
    reset_pulse();
    for (int k = 0; k < 6; k++) begin
      idle(1);
      check("discard_rd_valid", int'(rd_valid), 0);
    end

    // randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0,
           16'($urandom), 2'($urandom), 16'($urandom));
      if ($urandom_range(0, 199) == 0) reset_pulse();
    end
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
